// File: rtl/rom_load_sequencer_if.sv
// rom_load_sequencer_if
//
// Purpose: bundles the HPS ioctl download stream, the ROM/RAM write port
// toward williams2, and the core control/status lines into one interface.
//
// Signals:
//   dl_active  ioctl_download level
//   dl_index   ioctl_index (8)
//   dl_wr      ioctl_wr byte strobe
//   dl_addr    ioctl_addr (17)
//   dl_data    ioctl_dout (8)
//   dl_wait    ioctl_wait back-pressure
//   rom_wr     write request to target
//   rom_sel    target region: 0=prog, 1=gfx, 2=snd
//   rom_addr   offset within the selected region (17)
//   rom_data   write data (8)
//   rom_ack    target accepted current write
//   core_reset active-high reset to williams2
//   dl_done    ROM image loaded and core released
//   dl_error   sticky error for the current download
//   checksum   modulo-256 sum of retired bytes (only with ROM_CHECKSUM_EN)
//
// Modports:
//   master  the environment side (HPS bridge plus ROM targets)
//   slave   the sequencer itself
//
// Optional feature macro: ROM_CHECKSUM_EN adds the checksum signal.

interface rom_load_sequencer_if;
    logic        dl_active;
    logic [7:0]  dl_index;
    logic        dl_wr;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        rom_wr;
    logic [1:0]  rom_sel;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ack;
    logic        core_reset;
    logic        dl_done;
    logic        dl_error;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    modport master (
`ifdef ROM_CHECKSUM_EN
        input  checksum,
`endif
        output dl_active, dl_index, dl_wr, dl_addr, dl_data, rom_ack,
        input  dl_wait, rom_wr, rom_sel, rom_addr, rom_data,
        input  core_reset, dl_done, dl_error
    );

    modport slave (
`ifdef ROM_CHECKSUM_EN
        output checksum,
`endif
        input  dl_active, dl_index, dl_wr, dl_addr, dl_data, rom_ack,
        output dl_wait, rom_wr, rom_sel, rom_addr, rom_data,
        output core_reset, dl_done, dl_error
    );
endinterface

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//
// Purpose: sits between the HPS ioctl download stream and the williams2
// ROM/RAM loading ports. Incoming bytes are range-checked, decoded into a
// target region (program, graphics, sound) and queued in a small FIFO; the
// FIFO head is offered to the target with a rom_wr/rom_ack handshake. The
// game core is held in reset from power-up until the download has drained
// and a settle delay has elapsed. Size and overflow problems raise a
// sticky dl_error for the current download.
//
// Ports:
//   clk_sys  system clock (48 MHz domain)
//   reset_n  synchronous, active-low reset
//   bus      rom_load_sequencer_if.slave carrying the download stream,
//            the ROM write port and the core control/status lines
//
// Optional feature macro: ROM_CHECKSUM_EN adds an 8-bit running sum of
// every retired byte on bus.checksum, cleared when a load starts.

module rom_load_sequencer #(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [16:0] GFX_BASE    = 17'h0C000,
    parameter logic [16:0] SND_BASE    = 17'h18000,
    parameter logic [16:0] ROM_SIZE    = 17'h1C000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HOLD_CYCLES = 16
) (
    input logic                 clk_sys,
    input logic                 reset_n,
    rom_load_sequencer_if.slave bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL   = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]  OCC_WAIT   = OCC_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [16:0] offset;
        logic [7:0]  data;
    } entry_t;

    state_t            state;
    state_t            state_next;
    entry_t            fifo_mem [FIFO_DEPTH];
    entry_t            entry_in;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W-1:0]  occupancy_next;
    logic [16:0]       byte_count;
    logic [HOLD_W-1:0] hold_count;
    logic              error_flag;
    logic              dl_wait_q;
    logic              fifo_empty;
    logic              fifo_full;
    logic              wr_req;
    logic              addr_ok;
    logic              push;
    logic              push_reject;
    logic              pop;
    logic              start_load;
    logic              enter_load;
    logic              enter_done;

    // Push/pop qualification. A full FIFO rejects a write even if the head
    // retires on the same edge, so the overflow rule does not depend on ack.
    always_comb begin
        fifo_empty  = (occupancy == '0);
        fifo_full   = (occupancy == OCC_FULL);
        wr_req      = bus.dl_wr && (state == LOAD);
        addr_ok     = (bus.dl_addr < ROM_SIZE);
        push        = wr_req && addr_ok && !fifo_full;
        push_reject = wr_req && !(addr_ok && !fifo_full);
        pop         = !fifo_empty && bus.rom_ack;
        start_load  = bus.dl_active && (bus.dl_index == ROM_INDEX);
        head        = fifo_mem[rd_ptr];
    end

    // Region decode happens once, at push time, so the write side only has
    // to replay the stored entry.
    always_comb begin
        entry_in.data = bus.dl_data;
        if (bus.dl_addr < GFX_BASE) begin
            entry_in.sel    = 2'd0;
            entry_in.offset = bus.dl_addr;
        end else if (bus.dl_addr < SND_BASE) begin
            entry_in.sel    = 2'd1;
            entry_in.offset = bus.dl_addr - GFX_BASE;
        end else begin
            entry_in.sel    = 2'd2;
            entry_in.offset = bus.dl_addr - SND_BASE;
        end
    end

    always_comb begin
        occupancy_next = occupancy;
        if (push && !pop) begin
            occupancy_next = occupancy + OCC_W'(1);
        end else if (!push && pop) begin
            occupancy_next = occupancy - OCC_W'(1);
        end
    end

    // Next-state logic. DRAIN looks at the occupancy after this edge so the
    // settle delay starts on the very edge that retires the last byte.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_load) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (!bus.dl_active) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (occupancy_next == '0) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_count == HOLD_LAST) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        enter_load = (state_next == LOAD) && (state != LOAD);
        enter_done = (state_next == DONE) && (state == HOLD);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || state != HOLD) begin
            hold_count <= '0;
        end else begin
            hold_count <= hold_count + HOLD_W'(1);
        end
    end

    // FIFO storage needs no reset: the pointers and occupancy define what
    // is valid, and reset empties the queue.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry_in;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            dl_wait_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occupancy <= occupancy_next;
            dl_wait_q <= (occupancy_next >= OCC_WAIT);
        end
    end

    // Byte count and sticky error. The size check is made once, on the
    // edge that releases the core.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            byte_count <= '0;
            error_flag <= 1'b0;
        end else if (enter_load) begin
            byte_count <= '0;
            error_flag <= 1'b0;
        end else begin
            if (push && byte_count != {17{1'b1}}) begin
                byte_count <= byte_count + 17'd1;
            end
            if (push_reject || (enter_done && byte_count != ROM_SIZE)) begin
                error_flag <= 1'b1;
            end
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n || enter_load) begin
            checksum_q <= 8'd0;
        end else if (pop && state != DONE) begin
            checksum_q <= checksum_q + head.data;
        end
    end

    assign bus.checksum = checksum_q;
`endif

    // The write port shows zeros while idle so it rests at its reset value.
    assign bus.rom_wr     = !fifo_empty;
    assign bus.rom_sel    = fifo_empty ? 2'd0 : head.sel;
    assign bus.rom_addr   = fifo_empty ? 17'd0 : head.offset;
    assign bus.rom_data   = fifo_empty ? 8'd0 : head.data;
    assign bus.dl_wait    = dl_wait_q;
    assign bus.core_reset = (state != DONE);
    assign bus.dl_done    = (state == DONE);
    assign bus.dl_error   = error_flag;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer
//
// Purpose: self-checking bench for rom_load_sequencer. A queue-based model
// tracks the expected FIFO contents, load phase, byte count and error, and
// every cycle the DUT outputs are compared against it. Directed scenarios
// add literal expectations for region boundaries, back-pressure, overflow,
// short loads, out-of-range bytes and reset mid-download.
//
// The region map is scaled down (GFX 0x0C00, SND 0x1800, size 0x1C00) so a
// complete download fits comfortably in simulation time; the boundaries
// keep the same shape as the real map.

module tb_rom_load_sequencer;

    localparam logic [7:0]  ROM_INDEX   = 8'd0;
    localparam logic [16:0] GFX_BASE    = 17'h00C00;
    localparam logic [16:0] SND_BASE    = 17'h01800;
    localparam logic [16:0] ROM_SIZE    = 17'h01C00;
    localparam int          FIFO_DEPTH  = 4;
    localparam int          HOLD_CYCLES = 16;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_HOLD  = 3;
    localparam int P_DONE  = 4;

    typedef struct packed {
        logic [1:0]  sel;
        logic [16:0] off;
        logic [7:0]  data;
    } ent_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    rom_load_sequencer_if bus ();

    rom_load_sequencer #(
        .ROM_INDEX   (ROM_INDEX),
        .GFX_BASE    (GFX_BASE),
        .SND_BASE    (SND_BASE),
        .ROM_SIZE    (ROM_SIZE),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    bit checking   = 1'b0;

    // Model state
    ent_t       mq[$];
    int         m_phase     = P_IDLE;
    int         m_count     = 0;
    bit         m_err       = 1'b0;
    int         m_hold_left = 0;
    logic [7:0] m_cks       = 8'd0;

    // Observed retires and timing
    logic [1:0]  ret_sel  [0:8191];
    logic [16:0] ret_off  [0:8191];
    logic [7:0]  ret_data [0:8191];
    int ret_n            = 0;
    int last_retire_edge = -1;
    int done_edge        = -1;
    bit done_prev        = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    function automatic ent_t decode(input logic [16:0] a, input logic [7:0] d);
        ent_t e;
        e.data = d;
        if (a >= SND_BASE) begin
            e.sel = 2'd2;
            e.off = a - SND_BASE;
        end else if (a >= GFX_BASE) begin
            e.sel = 2'd1;
            e.off = a - GFX_BASE;
        end else begin
            e.sel = 2'd0;
            e.off = a;
        end
        return e;
    endfunction

    // Model update on each rising edge from the inputs in force at that edge.
    always @(posedge clk_sys) begin
        int old_phase;
        bit do_pop;
        bit was_full;
        cycle++;
        if (!reset_n) begin
            mq.delete();
            m_phase     = P_IDLE;
            m_count     = 0;
            m_err       = 1'b0;
            m_hold_left = 0;
            m_cks       = 8'd0;
        end else begin
            old_phase = m_phase;
            do_pop    = (mq.size() > 0) && bus.rom_ack;
            was_full  = (mq.size() == FIFO_DEPTH);
            if (do_pop) begin
                m_cks = m_cks + mq[0].data;
                void'(mq.pop_front());
            end
            case (old_phase)
                P_IDLE, P_DONE: begin
                    if (bus.dl_active && bus.dl_index == ROM_INDEX) begin
                        m_phase = P_LOAD;
                        m_count = 0;
                        m_err   = 1'b0;
                        m_cks   = 8'd0;
                    end
                end
                P_LOAD: begin
                    if (bus.dl_wr) begin
                        if (bus.dl_addr >= ROM_SIZE || was_full) begin
                            m_err = 1'b1;
                        end else begin
                            mq.push_back(decode(bus.dl_addr, bus.dl_data));
                            if (m_count < 32'h1FFFF) m_count++;
                        end
                    end
                    if (!bus.dl_active) m_phase = P_DRAIN;
                end
                P_DRAIN: begin
                    if (mq.size() == 0) begin
                        m_phase     = P_HOLD;
                        m_hold_left = HOLD_CYCLES;
                    end
                end
                P_HOLD: begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        m_phase = P_DONE;
                        if (m_count != int'(ROM_SIZE)) m_err = 1'b1;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Compare and observe on the falling edge, away from the active edge.
    always @(negedge clk_sys) begin
        if (checking) begin
            checkOutput("rom_wr", bus.rom_wr, mq.size() != 0);
            if (mq.size() != 0) begin
                checkOutput("rom_sel",  bus.rom_sel,  mq[0].sel);
                checkOutput("rom_addr", bus.rom_addr, mq[0].off);
                checkOutput("rom_data", bus.rom_data, mq[0].data);
            end
            checkOutput("dl_wait",    bus.dl_wait,    mq.size() >= FIFO_DEPTH - 1);
            checkOutput("core_reset", bus.core_reset, m_phase != P_DONE);
            checkOutput("dl_done",    bus.dl_done,    m_phase == P_DONE);
            checkOutput("dl_error",   bus.dl_error,   m_err);
`ifdef ROM_CHECKSUM_EN
            checkOutput("checksum",   bus.checksum,   m_cks);
`endif
            if (bus.rom_wr && bus.rom_ack) begin
                if (ret_n < 8192) begin
                    ret_sel[ret_n]  = bus.rom_sel;
                    ret_off[ret_n]  = bus.rom_addr;
                    ret_data[ret_n] = bus.rom_data;
                end
                ret_n++;
                last_retire_edge = cycle + 1;
            end
            if (bus.dl_done && !done_prev) done_edge = cycle;
            done_prev = bus.dl_done;
        end
    end

    // Drive one cycle's worth of inputs shortly after the rising edge.
    task automatic applyStimulus(input bit active, input logic [7:0] idx,
                                 input bit wr, input logic [16:0] addr,
                                 input logic [7:0] data, input bit ack);
        @(posedge clk_sys);
        #2;
        bus.dl_active = active;
        bus.dl_index  = idx;
        bus.dl_wr     = wr;
        bus.dl_addr   = addr;
        bus.dl_data   = data;
        bus.rom_ack   = ack;
    endtask

    task automatic clearObservations();
        ret_n            = 0;
        last_retire_edge = -1;
        done_edge        = -1;
    endtask

    // Streams addresses 0..nbytes-1 with data=addr[7:0]; dl_active drops
    // together with the final byte.
    task automatic fullDownload(input int nbytes);
        int guard;
        clearObservations();
        applyStimulus(1'b1, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b1);
        for (int a = 0; a < nbytes; a++) begin
            guard = 0;
            while (bus.dl_wait && guard < 64) begin
                applyStimulus(1'b1, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b1);
                guard++;
            end
            applyStimulus(a != nbytes - 1, ROM_INDEX, 1'b1, 17'(a), 8'(a), 1'b1);
        end
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b1);
    endtask

    task automatic waitDone(input string name, input int limit);
        int n;
        n = 0;
        while (!bus.dl_done && n < limit) begin
            @(posedge clk_sys);
            #2;
            n++;
        end
        if (!bus.dl_done) checkOutput(name, bus.dl_done, 1'b1);
        @(negedge clk_sys);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.dl_active = 1'b0;
        bus.dl_index  = 8'd0;
        bus.dl_wr     = 1'b0;
        bus.dl_addr   = 17'd0;
        bus.dl_data   = 8'd0;
        bus.rom_ack   = 1'b1;
        @(posedge clk_sys);
        #2;
        checking = 1'b1;
        repeat (2) @(posedge clk_sys);
        #2;
        reset_n = 1'b1;

        $display("[TB] reset then idle");
        repeat (100) applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b1);
        checkOutput("idle_core_reset", bus.core_reset, 1'b1);
        checkOutput("idle_dl_done",    bus.dl_done,    1'b0);
        checkOutput("idle_rom_wr",     bus.rom_wr,     1'b0);
        checkOutput("idle_dl_wait",    bus.dl_wait,    1'b0);

        $display("[TB] foreign index ignored");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 8'd1, 1'b1, 17'(i), 8'h5A, 1'b1);
        applyStimulus(1'b0, 8'd1, 1'b0, 17'd0, 8'd0, 1'b1);
        checkOutput("foreign_rom_wr",     bus.rom_wr,     1'b0);
        checkOutput("foreign_core_reset", bus.core_reset, 1'b1);

        $display("[TB] full download");
        fullDownload(int'(ROM_SIZE));
        waitDone("full_done_timeout", 200);
        checkOutput("full_retire_count", ret_n, 32'h1C00);
        checkOutput("prog_last_sel",  ret_sel[32'h0BFF],  2'd0);
        checkOutput("prog_last_off",  ret_off[32'h0BFF],  17'h00BFF);
        checkOutput("prog_last_data", ret_data[32'h0BFF], 8'hFF);
        checkOutput("gfx_first_sel",  ret_sel[32'h0C00],  2'd1);
        checkOutput("gfx_first_off",  ret_off[32'h0C00],  17'd0);
        checkOutput("gfx_first_data", ret_data[32'h0C00], 8'h00);
        checkOutput("snd_5_sel",      ret_sel[32'h1805],  2'd2);
        checkOutput("snd_5_off",      ret_off[32'h1805],  17'd5);
        checkOutput("snd_5_data",     ret_data[32'h1805], 8'h05);
        checkOutput("snd_last_off",   ret_off[32'h1BFF],  17'h003FF);
        checkOutput("full_done_delay", done_edge - last_retire_edge, 16);
        checkOutput("full_dl_done",   bus.dl_done,    1'b1);
        checkOutput("full_core_rel",  bus.core_reset, 1'b0);
        checkOutput("full_dl_error",  bus.dl_error,   1'b0);
`ifdef ROM_CHECKSUM_EN
        checkOutput("full_checksum",  bus.checksum,   8'h00);
`endif

        $display("[TB] ack held low with back-pressure");
        clearObservations();
        applyStimulus(1'b1, ROM_INDEX, 1'b0, 17'd0, 8'd0,  1'b0);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'd0, 8'hA0, 1'b0);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'd1, 8'hA1, 1'b0);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'd2, 8'hA2, 1'b0);
        checkOutput("bp_wait_at_2", bus.dl_wait, 1'b0);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'd3, 8'hA3, 1'b0);
        checkOutput("bp_wait_at_3", bus.dl_wait, 1'b1);
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b0);
        checkOutput("bp_wait_at_4", bus.dl_wait,  1'b1);
        checkOutput("bp_head_data", bus.rom_data, 8'hA0);
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b0);
        checkOutput("bp_head_held",  bus.rom_data,   8'hA0);
        checkOutput("bp_core_reset", bus.core_reset, 1'b1);
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b1);
        waitDone("bp_done_timeout", 100);
        checkOutput("bp_retire_count", ret_n, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_order_data", ret_data[i], 8'hA0 + 8'(i));
            checkOutput("bp_order_off",  ret_off[i],  17'(i));
        end
        checkOutput("bp_done_delay", done_edge - last_retire_edge, 16);
        checkOutput("bp_size_error", bus.dl_error, 1'b1);
`ifdef ROM_CHECKSUM_EN
        checkOutput("bp_checksum", bus.checksum, 8'h86);
`endif

        $display("[TB] overflow when dl_wait ignored");
        clearObservations();
        applyStimulus(1'b1, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'h10 + 17'(i), 8'hB0 + 8'(i), 1'b0);
            if (i == 0) checkOutput("ovf_error_cleared", bus.dl_error, 1'b0);
        end
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b0);
        checkOutput("ovf_error_set",  bus.dl_error, 1'b1);
        checkOutput("ovf_not_done",   bus.dl_done,  1'b0);
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b1);
        waitDone("ovf_done_timeout", 100);
        checkOutput("ovf_retire_count", ret_n, 4);
        checkOutput("ovf_last_off",     ret_off[3],  17'h13);
        checkOutput("ovf_last_data",    ret_data[3], 8'hB3);
        checkOutput("ovf_dl_done",      bus.dl_done,  1'b1);
        checkOutput("ovf_dl_error",     bus.dl_error, 1'b1);

        $display("[TB] short download of 0x100 bytes");
        fullDownload(256);
        waitDone("short_done_timeout", 100);
        checkOutput("short_retire_count", ret_n, 256);
        checkOutput("short_dl_done",  bus.dl_done,  1'b1);
        checkOutput("short_dl_error", bus.dl_error, 1'b1);
`ifdef ROM_CHECKSUM_EN
        checkOutput("short_checksum", bus.checksum, 8'h80);
`endif

        $display("[TB] out-of-range byte");
        clearObservations();
        applyStimulus(1'b1, ROM_INDEX, 1'b0, 17'd0,     8'd0,  1'b1);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'h01C00, 8'h55, 1'b1);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'h01BFF, 8'h66, 1'b1);
        checkOutput("oor_error",  bus.dl_error, 1'b1);
        checkOutput("oor_rom_wr", bus.rom_wr,   1'b0);
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b1);
        waitDone("oor_done_timeout", 100);
        checkOutput("oor_retire_count", ret_n, 1);
        checkOutput("oor_kept_sel",  ret_sel[0],  2'd2);
        checkOutput("oor_kept_off",  ret_off[0],  17'h003FF);
        checkOutput("oor_kept_data", ret_data[0], 8'h66);

        $display("[TB] reset mid-load");
        applyStimulus(1'b1, ROM_INDEX, 1'b0, 17'd0, 8'd0,  1'b0);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'd0, 8'hC0, 1'b0);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'd1, 8'hC1, 1'b0);
        applyStimulus(1'b1, ROM_INDEX, 1'b1, 17'd2, 8'hC2, 1'b0);
        applyStimulus(1'b1, ROM_INDEX, 1'b0, 17'd0, 8'd0,  1'b0);
        checkOutput("rst_queued_wr",   bus.rom_wr,  1'b1);
        checkOutput("rst_queued_wait", bus.dl_wait, 1'b1);
        reset_n = 1'b0;
        applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b0);
        reset_n = 1'b1;
        checkOutput("rst_rom_wr",     bus.rom_wr,     1'b0);
        checkOutput("rst_dl_wait",    bus.dl_wait,    1'b0);
        checkOutput("rst_core_reset", bus.core_reset, 1'b1);
        checkOutput("rst_dl_done",    bus.dl_done,    1'b0);
        checkOutput("rst_dl_error",   bus.dl_error,   1'b0);
        repeat (5) applyStimulus(1'b0, ROM_INDEX, 1'b0, 17'd0, 8'd0, 1'b1);
        checkOutput("rst_idle_done",  bus.dl_done,    1'b0);
        checkOutput("rst_idle_wr",    bus.rom_wr,     1'b0);
        fullDownload(int'(ROM_SIZE));
        waitDone("reload_done_timeout", 200);
        checkOutput("reload_retire_count", ret_n, 32'h1C00);
        checkOutput("reload_first_data",   ret_data[0], 8'h00);
        checkOutput("reload_dl_done",      bus.dl_done,  1'b1);
        checkOutput("reload_dl_error",     bus.dl_error, 1'b0);

        repeat (3) @(posedge clk_sys);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
